// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer with BCD digit outputs.
// Supports preset load, start/pause/resume, a done level and a one-cycle done strobe.
// Optional feature: define TIMER_WARN_EN to enable the low-time warn output.
module countdown_timer_bcd #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter logic [7:0]  RESET_MIN = 8'h01,
    parameter logic [7:0]  RESET_SEC = 8'h00,
    parameter int unsigned WARN_SEC  = 10
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       tick,
    output logic       done,
    output logic       done_pulse,
    output logic       warn
);

    localparam int unsigned     PS_W   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [3:0]      mt_q, mo_q, st_q, so_q;
    logic [3:0]      mt_d, mo_d, st_d, so_d;
    logic [3:0]      dec_mt, dec_mo, dec_st, dec_so;
    logic            tick_q, tick_d;
    logic            done_pulse_q, done_pulse_d;
    logic            is_zero, dec_zero, sec_end;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign is_zero  = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) &&
                      (dec_so == 4'd0);
    // Last prescaler cycle of a second while counting.
    assign sec_end  = (state_q == StRun) && (ps_q == PS_MAX);

    // BCD decrement with borrow chain; holds at 00:00.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (!is_zero) begin
            if (so_q != 4'd0) begin
                dec_so = so_q - 4'd1;
            end else begin
                dec_so = 4'd9;
                if (st_q != 4'd0) begin
                    dec_st = st_q - 4'd1;
                end else begin
                    dec_st = 4'd5;
                    if (mo_q != 4'd0) begin
                        dec_mo = mo_q - 4'd1;
                    end else begin
                        dec_mo = 4'd9;
                        if (mt_q != 4'd0) begin
                            dec_mt = mt_q - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load beats start beats pause.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = is_zero ? StDone : StRun;
                    end
                end
                StRun: begin
                    // A decrement landing on 00:00 takes precedence over pause.
                    if (sec_end && dec_zero) begin
                        state_d = StDone;
                    end else if (pause && !start) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    if (start) begin
                        state_d = StRun;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next values: prescaler, digits and strobes.
    always_comb begin
        ps_d         = ps_q;
        mt_d         = mt_q;
        mo_d         = mo_q;
        st_d         = st_q;
        so_d         = so_q;
        tick_d       = 1'b0;
        done_pulse_d = 1'b0;
        if (load) begin
            ps_d = '0;
            mt_d = clamp(load_min[7:4], 4'd9);
            mo_d = clamp(load_min[3:0], 4'd9);
            st_d = clamp(load_sec[7:4], 4'd5);
            so_d = clamp(load_sec[3:0], 4'd9);
        end else if (state_q == StIdle) begin
            if (start) begin
                ps_d         = '0;
                done_pulse_d = is_zero;
            end
        end else if (state_q == StRun) begin
            if (sec_end) begin
                ps_d         = '0;
                mt_d         = dec_mt;
                mo_d         = dec_mo;
                st_d         = dec_st;
                so_d         = dec_so;
                tick_d       = 1'b1;
                done_pulse_d = dec_zero;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ps_q         <= '0;
            mt_q         <= RESET_MIN[7:4];
            mo_q         <= RESET_MIN[3:0];
            st_q         <= RESET_SEC[7:4];
            so_q         <= RESET_SEC[3:0];
            tick_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            ps_q         <= ps_d;
            mt_q         <= mt_d;
            mo_q         <= mo_d;
            st_q         <= st_d;
            so_q         <= so_d;
            tick_q       <= tick_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Outputs, all taken from registered state.
    always_comb begin
        min_tens   = mt_q;
        min_ones   = mo_q;
        sec_tens   = st_q;
        sec_ones   = so_q;
        running    = (state_q == StRun);
        done       = (state_q == StDone);
        tick       = tick_q;
        done_pulse = done_pulse_q;
    end

`ifdef TIMER_WARN_EN
    logic       warn_q, warn_d;
    logic [6:0] sec_val_d;

    // Warn computed from next-state values so it lines up with the shown digits.
    always_comb begin
        sec_val_d = 7'(st_d) * 7'd10 + 7'(so_d);
        warn_d    = ((state_d == StRun) || (state_d == StPause)) &&
                    (mt_d == 4'd0) && (mo_d == 4'd0) && (sec_val_d <= 7'(WARN_SEC));
    end

    // Warn register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with CLK_HZ=4 and a scoreboard queue.
module tb_countdown_timer_bcd;

`ifdef TIMER_WARN_EN
    localparam logic W = 1'b1;
`else
    localparam logic W = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn, start, pause, load;
    logic [7:0] load_min, load_sec;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, tick, done, done_pulse, warn;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    countdown_timer_bcd #(
        .CLK_HZ   (4),
        .RESET_MIN(8'h01),
        .RESET_SEC(8'h00),
        .WARN_SEC (10)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .pause     (pause),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .tick      (tick),
        .done      (done),
        .done_pulse(done_pulse),
        .warn      (warn)
    );

    // Layout: {digits MM:SS, running, tick, done, done_pulse, warn}
    function automatic logic [20:0] mk(input logic [15:0] d, input logic r, input logic t,
                                       input logic dn, input logic dp, input logic w);
        return {d, r, t, dn, dp, w};
    endfunction

    function automatic logic [20:0] obs();
        return {min_tens, min_ones, sec_tens, sec_ones, running, tick, done, done_pulse, warn};
    endfunction

    task automatic expect_push(input string tag, input logic [20:0] e);
        sb_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic sb_check();
        sb_t item;
        logic [20:0] o;
        item = sb.pop_front();
        o = obs();
        checks++;
        assert (o === item.exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", item.tag, o, item.exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [20:0] e);
        expect_push(tag, e);
        sb_check();
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_min = m;
        load_sec = s;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;
        cyc(2);
        expect_now("reset_values", mk(16'h0100, 0, 0, 0, 0, 0));
        resetn = 1'b1;
        cyc(1);
        expect_now("idle_after_reset", mk(16'h0100, 0, 0, 0, 0, 0));

        // First second from 01:00.
        do_start();
        expect_now("run_started", mk(16'h0100, 1, 0, 0, 0, 0));
        cyc(3);
        expect_now("no_tick_early", mk(16'h0100, 1, 0, 0, 0, 0));
        cyc(1);
        expect_now("first_decrement", mk(16'h0059, 1, 1, 0, 0, 0));
        cyc(1);
        expect_now("tick_one_cycle", mk(16'h0059, 1, 0, 0, 0, 0));

        // Mid-run load, then count 00:02 down to done.
        do_load(8'h00, 8'h02);
        expect_now("midrun_load", mk(16'h0002, 0, 0, 0, 0, 0));
        do_start();
        cyc(4);
        expect_now("at_0001", mk(16'h0001, 1, 1, 0, 0, W));
        cyc(4);
        expect_now("reach_done", mk(16'h0000, 0, 1, 1, 1, 0));
        cyc(1);
        expect_now("done_pulse_drop", mk(16'h0000, 0, 0, 1, 0, 0));
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        expect_now("done_ignores_start", mk(16'h0000, 0, 0, 1, 0, 0));

        // Borrow chains.
        do_load(8'h10, 8'h00);
        expect_now("load_clears_done", mk(16'h1000, 0, 0, 0, 0, 0));
        do_start();
        cyc(4);
        expect_now("borrow_1000", mk(16'h0959, 1, 1, 0, 0, 0));
        do_load(8'h00, 8'h10);
        expect_now("idle_no_warn", mk(16'h0010, 0, 0, 0, 0, 0));
        do_start();
        expect_now("warn_at_0010", mk(16'h0010, 1, 0, 0, 0, W));
        cyc(4);
        expect_now("borrow_0010", mk(16'h0009, 1, 1, 0, 0, W));

        // Pause two cycles into a second, hold, resume.
        do_load(8'h05, 8'h00);
        do_start();
        cyc(1);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        expect_now("paused", mk(16'h0500, 0, 0, 0, 0, 0));
        cyc(20);
        expect_now("pause_hold", mk(16'h0500, 0, 0, 0, 0, 0));
        do_start();
        expect_now("resumed", mk(16'h0500, 1, 0, 0, 0, 0));
        cyc(1);
        expect_now("resume_wait", mk(16'h0500, 1, 0, 0, 0, 0));
        cyc(1);
        expect_now("resume_decrement", mk(16'h0459, 1, 1, 0, 0, 0));

        // Clamping.
        do_load(8'hAB, 8'h7C);
        expect_now("load_clamp", mk(16'h9959, 0, 0, 0, 0, 0));

        // Start at 00:00.
        do_load(8'h00, 8'h00);
        do_start();
        expect_now("zero_start_done", mk(16'h0000, 0, 0, 1, 1, 0));
        cyc(1);
        expect_now("zero_start_pulse_drop", mk(16'h0000, 0, 0, 1, 0, 0));

        // Load on the tick edge wins.
        do_load(8'h00, 8'h30);
        do_start();
        cyc(3);
        do_load(8'h00, 8'h45);
        expect_now("load_beats_tick", mk(16'h0045, 0, 0, 0, 0, 0));

        // Pause on the tick edge: decrement then pause.
        do_start();
        cyc(3);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        expect_now("tick_with_pause", mk(16'h0044, 0, 1, 0, 0, 0));

        // Async reset mid-run.
        do_start();
        cyc(2);
        resetn = 1'b0;
        #1;
        expect_now("async_reset", mk(16'h0100, 0, 0, 0, 0, 0));
        #2;
        resetn = 1'b1;
        cyc(1);
        expect_now("after_async_reset", mk(16'h0100, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
